ber_align_counter: RTL and testbench

Multi-channel bit-error-rate counter with automatic latency alignment. It sits after the per-channel slicers in the loopback transceiver and takes the local PRBS reference bits as a second input. For each channel it searches the reference-to-slicer delay, locks on the first error-free window, and then accumulates saturating bit and error counts. It replaces the fixed-delay per-channel BER counters and generalises them to NCH channels, so that I and Q become two instances of one datapath.

---
 rtl/ber_align_counter.sv | 142 ++++++++++++++
 tb/tb_ber_align_counter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_align_counter.sv
// Multi-channel BER counter: per channel, searches the reference-to-slicer delay, locks on the first clean window, then counts bits/errors.
// Optional loss-of-lock recovery is compiled in when BER_LOL_EN is defined.
//
// state     | meaning
// ST_SEARCH | trying one delay candidate per window of SEARCH_LEN steps
// ST_LOCKED | delay fixed, bit/error counters accumulating
module ber_align_counter #(
    parameter int NCH        = 2,
    parameter int CNT_W      = 64,
    parameter int DLY_W      = 4,
    parameter int SEARCH_LEN = 511,
    parameter int LOL_THRESH = 8
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_valid,
    input  logic                 i_clear,
    input  logic [NCH-1:0]       i_rx_bits,
    input  logic [NCH-1:0]       i_ref_bits,
    output logic [NCH-1:0]       o_err_pulse,
    output logic [NCH-1:0]       o_locked,
    output logic [NCH*DLY_W-1:0] o_delay,
    output logic [NCH*CNT_W-1:0] o_bit_count,
    output logic [NCH*CNT_W-1:0] o_err_count
);
    localparam int NTAP    = 2 ** DLY_W;
    localparam int WIN_MAX = (SEARCH_LEN > LOL_THRESH) ? SEARCH_LEN : LOL_THRESH;
    localparam int WIN_W   = $clog2(WIN_MAX + 1);
`ifdef BER_LOL_EN
    localparam bit LOL_RUN = 1'b1;
`else
    localparam bit LOL_RUN = 1'b0;
`endif

    typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t                    r_state     [NCH];
    state_t                    w_state_nxt [NCH];
    logic [NCH-1:0][NTAP-2:0]  r_hist;
    logic [NCH-1:0][DLY_W-1:0] r_delay;
    logic [NCH-1:0][WIN_W-1:0] r_win_cnt;
    logic [NCH-1:0][WIN_W-1:0] r_win_err;
    logic [NCH-1:0][CNT_W-1:0] r_bit_cnt;
    logic [NCH-1:0][CNT_W-1:0] r_err_cnt;
    logic [NCH-1:0]            r_err_pulse;

    logic                      w_step;
    logic [NCH-1:0][NTAP-1:0]  w_taps;
    logic [NCH-1:0]            w_cmp;
    logic [NCH-1:0][WIN_W-1:0] w_err_sum;
    logic [NCH-1:0]            w_win_end;
    logic [NCH-1:0]            w_lock_evt;
    logic [NCH-1:0]            w_lol_evt;

    assign w_step = i_enable & i_valid;

    always_ff @(posedge clock) begin
        for (int c = 0; c < NCH; c++) begin
            if (i_reset) r_state[c] <= ST_SEARCH;
            else         r_state[c] <= w_state_nxt[c];
        end
    end

    // tap[0] is the live reference bit, tap[d] the reference d steps back
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_taps[c]      = {r_hist[c], i_ref_bits[c]};
            w_cmp[c]       = i_rx_bits[c] ^ w_taps[c][r_delay[c]];
            w_err_sum[c]   = r_win_err[c] + WIN_W'(w_cmp[c]);
            w_win_end[c]   = w_step && (32'(r_win_cnt[c]) == SEARCH_LEN - 1);
            w_lock_evt[c]  = 1'b0;
            w_lol_evt[c]   = 1'b0;
            w_state_nxt[c] = r_state[c];
            case (r_state[c])
                ST_SEARCH: begin
                    if (w_win_end[c] && (w_err_sum[c] == '0)) begin
                        w_lock_evt[c]  = 1'b1;
                        w_state_nxt[c] = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
`ifdef BER_LOL_EN
                    if (w_step && (32'(w_err_sum[c]) == LOL_THRESH)) begin
                        w_lol_evt[c]   = 1'b1;
                        w_state_nxt[c] = ST_SEARCH;
                    end
`endif
                end
                default: w_state_nxt[c] = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_hist      <= '0;
            r_delay     <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_bit_cnt   <= '0;
            r_err_cnt   <= '0;
            r_err_pulse <= '0;
        end else begin
            r_err_pulse <= w_step ? w_cmp : '0;
            for (int c = 0; c < NCH; c++) begin
                if (w_step) begin
                    r_hist[c] <= w_taps[c][NTAP-2:0];
                    if (w_win_end[c] || w_lol_evt[c]) begin
                        r_win_cnt[c] <= '0;
                        r_win_err[c] <= '0;
                    end else if ((r_state[c] == ST_SEARCH) || LOL_RUN) begin
                        r_win_cnt[c] <= r_win_cnt[c] + WIN_W'(1);
                        r_win_err[c] <= w_err_sum[c];
                    end
                    if (w_lol_evt[c] || ((r_state[c] == ST_SEARCH) && w_win_end[c] && !w_lock_evt[c]))
                        r_delay[c] <= r_delay[c] + DLY_W'(1);
                end
                // a clear coinciding with a step drops that sample
                if (i_enable && i_clear) begin
                    r_bit_cnt[c] <= '0;
                    r_err_cnt[c] <= '0;
                end else if (w_step && (r_state[c] == ST_LOCKED)) begin
                    if (r_bit_cnt[c] != '1)
                        r_bit_cnt[c] <= r_bit_cnt[c] + CNT_W'(1);
                    if (w_cmp[c] && (r_err_cnt[c] != '1))
                        r_err_cnt[c] <= r_err_cnt[c] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++)
            o_locked[c] = (r_state[c] == ST_LOCKED);
        o_delay     = r_delay;
        o_bit_count = r_bit_cnt;
        o_err_count = r_err_cnt;
        o_err_pulse = r_err_pulse;
    end

endmodule

// File: tb/tb_ber_align_counter.sv
// Scoreboard bench for ber_align_counter: a 64-bit and an 8-bit counter instance share stimulus and are
// checked every cycle against a behavioural model, plus milestone checks taken from the test plan.
module tb_ber_align_counter;
    localparam int SLEN  = 511;
    localparam int LOL_T = 8;

    logic         clock = 1'b0;
    logic         i_reset, i_enable, i_valid, i_clear;
    logic [1:0]   i_rx_bits, i_ref_bits;
    logic [1:0]   o_err_pulse, o_locked, o8_err_pulse, o8_locked;
    logic [7:0]   o_delay, o8_delay;
    logic [127:0] o_bit_count, o_err_count;
    logic [15:0]  o8_bit_count, o8_err_count;

    always #5 clock = ~clock;

    ber_align_counter #(.NCH(2), .CNT_W(64), .DLY_W(4), .SEARCH_LEN(SLEN), .LOL_THRESH(LOL_T)) u_dut (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid), .i_clear(i_clear),
        .i_rx_bits(i_rx_bits), .i_ref_bits(i_ref_bits), .o_err_pulse(o_err_pulse), .o_locked(o_locked),
        .o_delay(o_delay), .o_bit_count(o_bit_count), .o_err_count(o_err_count));

    ber_align_counter #(.NCH(2), .CNT_W(8), .DLY_W(4), .SEARCH_LEN(SLEN), .LOL_THRESH(LOL_T)) u_dut8 (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid), .i_clear(i_clear),
        .i_rx_bits(i_rx_bits), .i_ref_bits(i_ref_bits), .o_err_pulse(o8_err_pulse), .o_locked(o8_locked),
        .o_delay(o8_delay), .o_bit_count(o8_bit_count), .o_err_count(o8_err_count));

    typedef struct packed {
        logic [1:0]   locked;
        logic [7:0]   delay;
        logic [1:0]   pulse;
        logic [127:0] bit64;
        logic [127:0] err64;
        logic [15:0]  bit8;
        logic [15:0]  err8;
    } exp_t;

    exp_t sb_q [$];
    int   n_total = 0;
    int   n_bad   = 0;

    // behavioural model state
    logic        m_locked [2];
    int          m_delay  [2];
    int          m_wcnt   [2];
    int          m_werr   [2];
    logic [15:0] m_hist   [2];
    logic [63:0] m_bit    [2];
    logic [63:0] m_err    [2];
    logic [7:0]  m_bit8   [2];
    logic [7:0]  m_err8   [2];
    logic [1:0]  m_pulse;
    int          m_steps;

    // stimulus generator state
    int          g_dly  [2];
    logic [15:0] g_hist [2];
    logic [14:0] g_lfsr [2];

    logic [1:0]  prev_lock;
    int          lock_step [2];
    int          pulse_cnt0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic en, input logic val, input logic clr,
                              input logic [1:0] rx, input logic [1:0] rf);
        logic tap, e;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_locked[c] = 1'b0; m_delay[c] = 0; m_wcnt[c] = 0; m_werr[c] = 0; m_hist[c] = '0;
                m_bit[c] = '0; m_err[c] = '0; m_bit8[c] = '0; m_err8[c] = '0;
            end
            m_pulse = 2'b00;
            m_steps = 0;
            return;
        end
        m_pulse = 2'b00;
        for (int c = 0; c < 2; c++) begin
            if (en && val) begin
                tap = (m_delay[c] == 0) ? rf[c] : m_hist[c][m_delay[c]-1];
                e = rx[c] ^ tap;
                m_pulse[c] = e;
                if (m_locked[c]) begin
                    if (m_bit[c] != {64{1'b1}}) m_bit[c] = m_bit[c] + 64'd1;
                    if (e && m_err[c] != {64{1'b1}}) m_err[c] = m_err[c] + 64'd1;
                    if (m_bit8[c] != 8'hff) m_bit8[c] = m_bit8[c] + 8'd1;
                    if (e && m_err8[c] != 8'hff) m_err8[c] = m_err8[c] + 8'd1;
`ifdef BER_LOL_EN
                    m_wcnt[c]++;
                    m_werr[c] += int'(e);
                    if (m_werr[c] == LOL_T) begin
                        m_locked[c] = 1'b0;
                        m_delay[c]  = (m_delay[c] + 1) % 16;
                        m_wcnt[c] = 0; m_werr[c] = 0;
                    end else if (m_wcnt[c] == SLEN) begin
                        m_wcnt[c] = 0; m_werr[c] = 0;
                    end
`endif
                end else begin
                    m_wcnt[c]++;
                    m_werr[c] += int'(e);
                    if (m_wcnt[c] == SLEN) begin
                        if (m_werr[c] == 0) m_locked[c] = 1'b1;
                        else                m_delay[c] = (m_delay[c] + 1) % 16;
                        m_wcnt[c] = 0; m_werr[c] = 0;
                    end
                end
                m_hist[c] = {m_hist[c][14:0], rf[c]};
            end
            if (en && clr) begin
                m_bit[c] = '0; m_err[c] = '0; m_bit8[c] = '0; m_err8[c] = '0;
            end
        end
        if (en && val) m_steps++;
    endtask

    task automatic cyc(input logic rst, input logic en, input logic val, input logic clr,
                       input logic [1:0] rx, input logic [1:0] rf);
        exp_t ex;
        @(negedge clock);
        i_reset = rst; i_enable = en; i_valid = val; i_clear = clr;
        i_rx_bits = rx; i_ref_bits = rf;
        model_step(rst, en, val, clr, rx, rf);
        ex.locked = {m_locked[1], m_locked[0]};
        ex.delay  = {4'(m_delay[1]), 4'(m_delay[0])};
        ex.pulse  = m_pulse;
        ex.bit64  = {m_bit[1], m_bit[0]};
        ex.err64  = {m_err[1], m_err[0]};
        ex.bit8   = {m_bit8[1], m_bit8[0]};
        ex.err8   = {m_err8[1], m_err8[0]};
        sb_q.push_back(ex);
        @(posedge clock);
        #1;
        ex = sb_q.pop_front();
        check_val("locked", 128'(o_locked), 128'(ex.locked));
        check_val("delay", 128'(o_delay), 128'(ex.delay));
        check_val("err_pulse", 128'(o_err_pulse), 128'(ex.pulse));
        check_val("bit_count", o_bit_count, ex.bit64);
        check_val("err_count", o_err_count, ex.err64);
        check_val("bit_count8", 128'(o8_bit_count), 128'(ex.bit8));
        check_val("err_count8", 128'(o8_err_count), 128'(ex.err8));
        check_val("ctl8", 128'({o8_locked, o8_delay, o8_err_pulse}), 128'({ex.locked, ex.delay, ex.pulse}));
        for (int c = 0; c < 2; c++)
            if (o_locked[c] && !prev_lock[c]) lock_step[c] = m_steps;
        prev_lock = o_locked;
        if (o_err_pulse[0]) pulse_cnt0++;
    endtask

    task automatic send(input logic en, input logic val, input logic clr, input logic [1:0] flip);
        logic [1:0] rf, rx;
        for (int c = 0; c < 2; c++) begin
            rf[c] = g_lfsr[c][14];
            rx[c] = ((g_dly[c] == 0) ? rf[c] : g_hist[c][g_dly[c]-1]) ^ flip[c];
        end
        cyc(1'b0, en, val, clr, rx, rf);
        if (en && val) begin
            for (int c = 0; c < 2; c++) begin
                g_hist[c] = {g_hist[c][14:0], rf[c]};
                g_lfsr[c] = {g_lfsr[c][13:0], g_lfsr[c][14] ^ g_lfsr[c][13]};
            end
        end
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 2'b00);
        g_hist[0] = '0; g_hist[1] = '0;
        lock_step[0] = -1; lock_step[1] = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, cy;
        i_reset = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_clear = 1'b0;
        i_rx_bits = 2'b00; i_ref_bits = 2'b00;
        prev_lock = 2'b00; pulse_cnt0 = 0;
        g_dly[0] = 5; g_dly[1] = 2;
        g_lfsr[0] = 15'h4b3d; g_lfsr[1] = 15'h1f29;
        do_reset();
        do_reset();
        check_val("rst_locked", 128'(o_locked), 128'd0);
        check_val("rst_delay", 128'(o_delay), 128'd0);

        // alignment search with clean PRBS
        for (int i = 0; i < 8000 && o_locked != 2'b11; i++) send(1'b1, 1'b1, 1'b0, 2'b00);
        check_val("lock_step0", 128'(lock_step[0]), 128'(6 * SLEN));
        check_val("lock_step1", 128'(lock_step[1]), 128'(3 * SLEN));
        check_val("lock_delay", 128'(o_delay), 128'h25);
        check_val("lock_bit0", 128'(o_bit_count[63:0]), 128'd0);
        check_val("lock_err0", 128'(o_err_count[63:0]), 128'd0);

        // one error every 100 steps, with idle cycles mixed in
        pulse_cnt0 = 0; s = 0; cy = 0;
        while (s < 10000) begin
            if (cy % 7 == 6) send(1'b1, 1'b0, 1'b0, 2'b00);
            else begin
                send(1'b1, 1'b1, 1'b0, (s % 100 == 99) ? 2'b01 : 2'b00);
                s++;
            end
            cy++;
        end
        check_val("run_bit0", 128'(o_bit_count[63:0]), 128'd10000);
        check_val("run_err0", 128'(o_err_count[63:0]), 128'd100);
        check_val("run_pulses0", 128'(pulse_cnt0), 128'd100);

        // saturation and clear
        send(1'b1, 1'b0, 1'b1, 2'b00);
        check_val("clr_bit", o_bit_count, 128'd0);
        for (int i = 0; i < 300; i++) send(1'b1, 1'b1, 1'b0, 2'b11);
`ifndef BER_LOL_EN
        check_val("sat_bit8", 128'(o8_bit_count), 128'hffff);
        check_val("sat_err8", 128'(o8_err_count), 128'hffff);
        check_val("inv_bit0", 128'(o_bit_count[63:0]), 128'd300);
`endif
        send(1'b1, 1'b1, 1'b1, 2'b11);
        check_val("clr_step_bit8", 128'(o8_bit_count), 128'd0);
        check_val("clr_step_err", o_err_count, 128'd0);
        send(1'b1, 1'b1, 1'b0, 2'b00);
`ifndef BER_LOL_EN
        check_val("post_clr_bit8", 128'(o8_bit_count), 128'h0101);
        check_val("post_clr_err8", 128'(o8_err_count), 128'd0);
`endif

        // enable low freezes everything
        for (int i = 0; i < 50; i++) send(1'b0, 1'((i % 2) == 1), 1'b0, 2'($urandom_range(0, 3)));
`ifndef BER_LOL_EN
        check_val("hold_delay", 128'(o_delay), 128'h25);
        check_val("hold_locked", 128'(o_locked), 128'd3);
`endif
        do_reset();
        check_val("rst_lock_locked", 128'(o_locked), 128'd0);
        check_val("rst_lock_bit", o_bit_count, 128'd0);
        for (int i = 0; i < 200; i++) send(1'b1, 1'b1, 1'b0, 2'b00);
        do_reset();
        check_val("rst_win_delay", 128'(o_delay), 128'd0);

        // uncorrelated rx walks the delay through a full wrap
        for (int w = 1; w <= 17; w++) begin
            for (int k = 0; k < SLEN; k++) send(1'b1, 1'b1, 1'b0, 2'($urandom_range(0, 3)));
            check_val("walk_delay0", 128'(o_delay[3:0]), 128'(w % 16));
            check_val("walk_delay1", 128'(o_delay[7:4]), 128'(w % 16));
            check_val("walk_locked", 128'(o_locked), 128'd0);
        end

        // burst of 8 errors on a locked channel
        do_reset();
        for (int i = 0; i < 8000 && !o_locked[0]; i++) send(1'b1, 1'b1, 1'b0, 2'b00);
        check_val("f_lock0", 128'(o_locked[0]), 128'd1);
        check_val("f_delay0", 128'(o_delay[3:0]), 128'd5);
        for (int i = 0; i < 8; i++) send(1'b1, 1'b1, 1'b0, 2'b01);
`ifdef BER_LOL_EN
        check_val("lol_locked0", 128'(o_locked[0]), 128'd0);
        check_val("lol_delay0", 128'(o_delay[3:0]), 128'd6);
        check_val("lol_bit0", 128'(o_bit_count[63:0]), 128'd8);
        check_val("lol_err0", 128'(o_err_count[63:0]), 128'd8);
        for (int i = 0; i < 10000 && !o_locked[0]; i++) send(1'b1, 1'b1, 1'b0, 2'b00);
        check_val("relock0", 128'(o_locked[0]), 128'd1);
        check_val("relock_delay0", 128'(o_delay[3:0]), 128'd5);
        check_val("relock_bit0", 128'(o_bit_count[63:0]), 128'd8);
`else
        check_val("keep_locked0", 128'(o_locked[0]), 128'd1);
        check_val("keep_delay0", 128'(o_delay[3:0]), 128'd5);
        check_val("burst_bit0", 128'(o_bit_count[63:0]), 128'd8);
        check_val("burst_err0", 128'(o_err_count[63:0]), 128'd8);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
